// File: rtl/descrambler_if.sv
// Lane word bundle between the RX block-sync stage and the descrambler.
// The master drives the *_IN side; the slave (descrambler) drives *_OUT.
interface descrambler_if #(
    parameter int W = 64
);
    logic [W-1:0] DATA_IN;
    logic [1:0]   HEADER_IN;
    logic         DATA_IN_VALID;
    logic [W-1:0] DATA_OUT;
    logic [1:0]   HEADER_OUT;
    logic         DATA_OUT_VALID;

    modport master (
        output DATA_IN, HEADER_IN, DATA_IN_VALID,
        input  DATA_OUT, HEADER_OUT, DATA_OUT_VALID
    );

    modport slave (
        input  DATA_IN, HEADER_IN, DATA_IN_VALID,
        output DATA_OUT, HEADER_OUT, DATA_OUT_VALID
    );
endinterface

// File: rtl/descrambler.sv
// RX lane descrambler: removes x^58+x^39+1 self-sync scrambling and tracks
// scrambler lock from state words. DESCRAMBLER_ERR_CNT_EN builds ERR_COUNT.
module descrambler #(
    parameter int                     RX_DATA_WIDTH  = 64,
    parameter logic [RX_DATA_WIDTH-1:0] SYNC_WORD    = 64'h78f678f678f678f6,
    parameter int                     MISMATCH_LIMIT = 3
) (
    input  logic         USER_CLK,
    input  logic         SYSTEM_RESET_N,
    input  logic         PASSTHROUGH,
    descrambler_if.slave lane,
    output logic         LOCKED,
    output logic         STATE_ERR,
    output logic [15:0]  ERR_COUNT
);

    localparam int LW = 58;

    typedef enum logic [1:0] {
        SEEK,
        SEEK_STATE,
        LOCK,
        LOCK_STATE
    } state_t;

    state_t                   state_q, state_d;
    logic [LW-1:0]            lfsr_q, lfsr_d, lfsr_scr;
    logic [RX_DATA_WIDTH-1:0] scr_out, data_q, data_d;
    logic [2:0]               mis_q, mis_d;
    logic                     err_d;
    logic                     is_sync, good_fmt;
    logic [LW-1:0]            st_bits;

    assign is_sync  = (lane.HEADER_IN == 2'b10) && (lane.DATA_IN == SYNC_WORD);
    assign good_fmt = lane.DATA_IN[RX_DATA_WIDTH-1 -: 6] == 6'b001010;
    assign st_bits  = lane.DATA_IN[LW-1:0];

    // Bit-serial descramble of the whole word, LSB first, received bit fed back
    always_comb begin
        lfsr_scr = lfsr_q;
        scr_out  = '0;
        for (int i = 0; i < RX_DATA_WIDTH; i++) begin
            scr_out[i] = lane.DATA_IN[i] ^ lfsr_scr[38] ^ lfsr_scr[57];
            lfsr_scr   = {lfsr_scr[56:0], lane.DATA_IN[i]};
        end
    end

    // Lock FSM next state, LFSR update and output word selection
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        mis_d   = mis_q;
        data_d  = data_q;
        err_d   = 1'b0;
        if (PASSTHROUGH) begin
            state_d = SEEK;
            lfsr_d  = '1;
            mis_d   = '0;
            data_d  = lane.DATA_IN;
        end else if (lane.DATA_IN_VALID) begin
            unique case (state_q)
                SEEK, LOCK: begin
                    if (is_sync) begin
                        data_d  = lane.DATA_IN;
                        state_d = (state_q == SEEK) ? SEEK_STATE : LOCK_STATE;
                    end else begin
                        data_d = scr_out;
                        lfsr_d = lfsr_scr;
                    end
                end
                SEEK_STATE: begin
                    if (is_sync) begin
                        data_d = lane.DATA_IN;
                    end else if (good_fmt) begin
                        data_d  = lane.DATA_IN;
                        lfsr_d  = st_bits;
                        mis_d   = '0;
                        state_d = LOCK;
                    end else begin
                        data_d  = scr_out;
                        lfsr_d  = lfsr_scr;
                        state_d = SEEK;
                    end
                end
                LOCK_STATE: begin
                    if (!is_sync && good_fmt && st_bits == lfsr_q) begin
                        data_d  = lane.DATA_IN;
                        mis_d   = '0;
                        state_d = LOCK;
                    end else begin
                        err_d = 1'b1;
                        if (is_sync) begin
                            data_d = lane.DATA_IN;
                        end else if (good_fmt) begin
                            data_d = lane.DATA_IN;
                            lfsr_d = st_bits;
                        end else begin
                            data_d = scr_out;
                            lfsr_d = lfsr_scr;
                        end
                        if (int'(mis_q) + 1 >= MISMATCH_LIMIT) begin
                            mis_d   = '0;
                            state_d = SEEK;
                        end else begin
                            mis_d   = mis_q + 3'd1;
                            state_d = LOCK;
                        end
                    end
                end
            endcase
        end
    end

    // State, LFSR and output pipeline registers
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            state_q             <= SEEK;
            lfsr_q              <= '1;
            mis_q               <= '0;
            data_q              <= '0;
            lane.HEADER_OUT     <= '0;
            lane.DATA_OUT_VALID <= 1'b0;
            STATE_ERR           <= 1'b0;
        end else begin
            state_q             <= state_d;
            lfsr_q              <= lfsr_d;
            mis_q               <= mis_d;
            data_q              <= data_d;
            lane.HEADER_OUT     <= lane.HEADER_IN;
            lane.DATA_OUT_VALID <= lane.DATA_IN_VALID;
            STATE_ERR           <= err_d;
        end
    end

    assign lane.DATA_OUT = data_q;
    assign LOCKED        = (state_q == LOCK) || (state_q == LOCK_STATE);

`ifdef DESCRAMBLER_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Saturating count of state-word errors, cleared only by reset
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            err_cnt_q <= '0;
        end else if (err_d && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign ERR_COUNT = err_cnt_q;
`else
    assign ERR_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_descrambler.sv
// Random and directed stimulus for descrambler, checked against a
// bit-stream reference model and a TX scrambler model for loopback.
module tb_descrambler;

    localparam logic [63:0] SYNC  = 64'h78f678f678f678f6;
    localparam int          LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pt;
    logic        locked, state_err;
    logic [15:0] err_count;

    descrambler_if #(.W(64)) lane ();

    descrambler dut (
        .USER_CLK       (clk),
        .SYSTEM_RESET_N (rst_n),
        .PASSTHROUGH    (pt),
        .lane           (lane),
        .LOCKED         (locked),
        .STATE_ERR      (state_err),
        .ERR_COUNT      (err_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    bit rx_q[$];
    bit tx_q[$];
    bit m_locked, m_after;
    int m_bad;

    logic [63:0] exp_data;
    logic [1:0]  exp_hdr;
    logic        exp_valid, exp_err;
    logic [15:0] exp_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Received-bit history: rx_q[$] is the newest bit, rx_q[57-j] is lfsr[j]
    task automatic m_fill_ones();
        rx_q.delete();
        repeat (58) rx_q.push_back(1'b1);
    endtask

    function automatic logic [57:0] m_lfsr();
        logic [57:0] r;
        for (int j = 0; j < 58; j++) r[j] = rx_q[57-j];
        return r;
    endfunction

    task automatic m_load(input logic [57:0] b);
        rx_q.delete();
        for (int j = 57; j >= 0; j--) rx_q.push_back(b[j]);
    endtask

    task automatic m_descr(input logic [63:0] d, output logic [63:0] o);
        for (int i = 0; i < 64; i++) begin
            o[i] = d[i] ^ rx_q[19] ^ rx_q[0];
            rx_q.push_back(d[i]);
            void'(rx_q.pop_front());
        end
    endtask

    task automatic tx_scr(input logic [63:0] d, output logic [63:0] o);
        for (int i = 0; i < 64; i++) begin
            o[i] = d[i] ^ tx_q[19] ^ tx_q[0];
            tx_q.push_back(o[i]);
            void'(tx_q.pop_front());
        end
    endtask

    function automatic logic [63:0] tx_state();
        logic [57:0] r;
        for (int j = 0; j < 58; j++) r[j] = tx_q[57-j];
        return {6'b001010, r};
    endfunction

    function automatic logic [63:0] st_word(input logic [57:0] b);
        return {6'b001010, b};
    endfunction

    task automatic m_init();
        m_fill_ones();
        m_locked  = 1'b0;
        m_after   = 1'b0;
        m_bad     = 0;
        exp_data  = '0;
        exp_hdr   = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_cnt   = '0;
    endtask

    // Word-level behaviour: sync / state-word / payload rules and lock tracking
    task automatic m_step(input logic [63:0] d, input logic [1:0] h,
                          input logic v, input logic p);
        logic        sync, fmt;
        logic [63:0] o;
        exp_hdr   = h;
        exp_valid = v;
        exp_err   = 1'b0;
        if (p) begin
            exp_data = d;
            m_fill_ones();
            m_locked = 1'b0;
            m_after  = 1'b0;
            m_bad    = 0;
            return;
        end
        if (!v) return;
        sync = (h == 2'b10) && (d == SYNC);
        fmt  = d[63:58] == 6'b001010;
        if (m_after && !m_locked) begin
            if (sync) begin
                exp_data = d;
            end else begin
                m_after = 1'b0;
                if (fmt) begin
                    exp_data = d;
                    m_load(d[57:0]);
                    m_locked = 1'b1;
                    m_bad    = 0;
                end else begin
                    m_descr(d, o);
                    exp_data = o;
                end
            end
        end else if (m_after) begin
            m_after = 1'b0;
            if (!sync && fmt && d[57:0] == m_lfsr()) begin
                exp_data = d;
                m_bad    = 0;
            end else begin
                exp_err = 1'b1;
                if (sync) begin
                    exp_data = d;
                end else if (fmt) begin
                    exp_data = d;
                    m_load(d[57:0]);
                end else begin
                    m_descr(d, o);
                    exp_data = o;
                end
                m_bad++;
                if (m_bad >= LIMIT) begin
                    m_locked = 1'b0;
                    m_bad    = 0;
                end
`ifdef DESCRAMBLER_ERR_CNT_EN
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
            end
        end else if (sync) begin
            exp_data = d;
            m_after  = 1'b1;
        end else begin
            m_descr(d, o);
            exp_data = o;
        end
    endtask

    task automatic step(input logic [63:0] d, input logic [1:0] h,
                        input logic v, input logic p);
        @(negedge clk);
        lane.DATA_IN       = d;
        lane.HEADER_IN     = h;
        lane.DATA_IN_VALID = v;
        pt                 = p;
        m_step(d, h, v, p);
        @(posedge clk);
        #1;
        chk("data", lane.DATA_OUT, exp_data);
        chk("hdr", {62'd0, lane.HEADER_OUT}, {62'd0, exp_hdr});
        chk("valid", {63'd0, lane.DATA_OUT_VALID}, {63'd0, exp_valid});
        chk("locked", {63'd0, locked}, {63'd0, m_locked});
        chk("state_err", {63'd0, state_err}, {63'd0, exp_err});
        chk("err_count", {48'd0, err_count}, {48'd0, exp_cnt});
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    logic [63:0] d, s;

    initial begin
        rst_n              = 1'b0;
        pt                 = 1'b0;
        lane.DATA_IN       = '0;
        lane.HEADER_IN     = '0;
        lane.DATA_IN_VALID = 1'b0;
        m_init();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", lane.DATA_OUT, 64'd0);
        chk("rst_valid", {63'd0, lane.DATA_OUT_VALID}, 64'd0);
        chk("rst_locked", {63'd0, locked}, 64'd0);
        chk("rst_err", {63'd0, state_err}, 64'd0);
        chk("rst_cnt", {48'd0, err_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (4) step(64'h0, 2'b01, 1'b1, 1'b0);
        step(rnd64(), 2'b01, 1'b0, 1'b0);

        step(SYNC, 2'b10, 1'b1, 1'b0);
        step(64'h28AB_CDEF_0123_4567, 2'b01, 1'b1, 1'b0);
        chk("acq_pass", lane.DATA_OUT, 64'h28AB_CDEF_0123_4567);
        chk("acq_lock", {63'd0, locked}, 64'd1);
        step(rnd64(), 2'b01, 1'b1, 1'b0);

        for (int k = 0; k < 3; k++) begin
            step(SYNC, 2'b10, 1'b1, 1'b0);
            step(st_word(m_lfsr() ^ 58'h5), 2'b01, 1'b1, 1'b0);
        end
        chk("drop_lock", {63'd0, locked}, 64'd0);

        step(SYNC, 2'b10, 1'b1, 1'b0);
        step(st_word(58'h123_4567_89AB_CDEF), 2'b01, 1'b1, 1'b0);
        step(rnd64(), 2'b01, 1'b1, 1'b0);
        step(SYNC, 2'b10, 1'b1, 1'b0);
        step(64'hFFFF_0000_FFFF_0000, 2'b01, 1'b1, 1'b0);
        chk("badfmt_err", {63'd0, state_err}, 64'd1);
        chk("badfmt_lock", {63'd0, locked}, 64'd1);
        step(SYNC, 2'b10, 1'b1, 1'b0);
        step(st_word(m_lfsr()), 2'b01, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(SYNC, 2'b10, 1'b1, 1'b0);
            step(st_word(~m_lfsr()), 2'b01, 1'b1, 1'b0);
        end
        chk("cnt_cleared", {63'd0, locked}, 64'd1);
        step(SYNC, 2'b10, 1'b1, 1'b0);
        step(st_word(m_lfsr()), 2'b01, 1'b1, 1'b0);

        d = rnd64();
        step(d, 2'b01, 1'b1, 1'b1);
        chk("pt_data", lane.DATA_OUT, d);
        chk("pt_lock", {63'd0, locked}, 64'd0);
        step(rnd64(), 2'b01, 1'b1, 1'b0);

        tx_q.delete();
        repeat (58) tx_q.push_back(1'($urandom));
        for (int n = 0; n < 1000; n++) begin
            if (n % 25 == 0) begin
                step(SYNC, 2'b10, 1'b1, 1'b0);
                step(tx_state(), 2'b01, 1'b1, 1'b0);
            end
            if ($urandom_range(7) == 0) step(rnd64(), 2'b00, 1'b0, 1'b0);
            d = rnd64();
            tx_scr(d, s);
            step(s, 2'b01, 1'b1, 1'b0);
            chk("loop_data", lane.DATA_OUT, d);
            chk("loop_err", {63'd0, state_err}, 64'd0);
        end

        @(negedge clk);
        lane.DATA_IN_VALID = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", lane.DATA_OUT, 64'd0);
        chk("arst_valid", {63'd0, lane.DATA_OUT_VALID}, 64'd0);
        chk("arst_locked", {63'd0, locked}, 64'd0);
        chk("arst_cnt", {48'd0, err_count}, 64'd0);
        m_init();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(st_word(58'h0AB_CDEF_0123_4567), 2'b01, 1'b1, 1'b0);
        chk("relock_need_sync", {63'd0, locked}, 64'd0);
        step(SYNC, 2'b10, 1'b1, 1'b0);
        step(st_word(58'h0AB_CDEF_0123_4567), 2'b01, 1'b1, 1'b0);
        chk("relock", {63'd0, locked}, 64'd1);
        repeat (4) step(rnd64(), 2'b01, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
